fpu_issue: RTL and testbench

Issue/writeback sequencer directly upstream of the FPU top. It accepts one floating-point request from the CPU core and holds the operands stable. It drives a one-cycle one-hot opcode pulse into the FPU, then waits for the FPU's out_valid. It returns result, overflow/underflow and error status to the core's FP register writeback through a valid/ready handshake, with a timeout guard against a hung unit.

---
 rtl/fpu_issue.sv | 183 ++++++++++++++++++
 tb/tb_fpu_issue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue.sv
// Issue/writeback sequencer in front of the FPU: latches one request, pulses a one-hot opcode,
// waits for the result (with timeout) and hands it back over valid/ready. Option: FPU_ISSUE_STICKY_FLAGS_EN.
module fpu_issue #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_x2,
    input  logic [4:0]  req_rd,
    output logic [9:0]  fpu_opcode,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    input  logic        fpu_ovf,
    input  logic        fpu_unf,
    input  logic        fpu_valid,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_ovf,
    output logic        wb_unf,
    output logic        wb_err,
    output logic        busy,
    input  logic        flags_clr,
    output logic [2:0]  flags
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [31:0] r_x1;
    logic [31:0] r_x2;
    logic [4:0]  r_rd;
    logic [7:0]  r_timer;
    logic [31:0] r_wb_data;
    logic        r_wb_ovf;
    logic        r_wb_unf;
    logic        r_wb_err;
    logic        w_illegal;
    logic        w_timeout;
    logic        w_wb_hs;

    assign w_illegal = (req_op > 4'd9);
    assign w_timeout = (r_timer == TIMER_LAST);
    assign w_wb_hs   = (r_state == S_WB) && wb_ready;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Handshake outputs decode only the state register, never req_valid or wb_ready.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        wb_valid   = 1'b0;
        fpu_opcode = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_next = w_illegal ? S_WB : S_ISSUE;
                end
            end
            S_ISSUE: begin
                fpu_opcode[r_op] = 1'b1;
                w_next           = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_valid || w_timeout) begin
                    w_next = S_WB;
                end
            end
            S_WB: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_op      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_rd      <= '0;
            r_timer   <= '0;
            r_wb_data <= '0;
            r_wb_ovf  <= 1'b0;
            r_wb_unf  <= 1'b0;
            r_wb_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op <= req_op;
                        r_x1 <= req_x1;
                        r_x2 <= req_x2;
                        r_rd <= req_rd;
                        if (w_illegal) begin
                            r_wb_data <= '0;
                            r_wb_ovf  <= 1'b0;
                            r_wb_unf  <= 1'b0;
                            r_wb_err  <= 1'b1;
                        end
                    end
                end
                S_ISSUE: r_timer <= '0;
                S_WAIT: begin
                    // A result arriving on the timeout cycle still counts as a good completion.
                    if (fpu_valid) begin
                        r_wb_data <= fpu_y;
                        r_wb_ovf  <= fpu_ovf;
                        r_wb_unf  <= fpu_unf;
                        r_wb_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_wb_data <= '0;
                        r_wb_ovf  <= 1'b0;
                        r_wb_unf  <= 1'b0;
                        r_wb_err  <= 1'b1;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FPU_ISSUE_STICKY_FLAGS_EN
    logic [2:0] r_flags;
    logic [2:0] w_done_bits;

    assign w_done_bits = {r_wb_err, r_wb_ovf, r_wb_unf};

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_flags <= '0;
        end else if (w_wb_hs) begin
            r_flags <= flags_clr ? w_done_bits : (r_flags | w_done_bits);
        end else if (flags_clr) begin
            r_flags <= '0;
        end
    end

    assign flags = r_flags;
`else
    logic w_unused;
    assign w_unused = flags_clr ^ w_wb_hs;
    assign flags    = '0;
`endif

    assign fpu_x1  = r_x1;
    assign fpu_x2  = r_x2;
    assign wb_rd   = r_rd;
    assign wb_data = r_wb_data;
    assign wb_ovf  = r_wb_ovf;
    assign wb_unf  = r_wb_unf;
    assign wb_err  = r_wb_err;

endmodule

// File: tb/tb_fpu_issue.sv
// Directed self-checking bench for fpu_issue (TIMEOUT_CYCLES=8); flag expectations follow
// FPU_ISSUE_STICKY_FLAGS_EN.
module tb_fpu_issue;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_x1 = '0;
    logic [31:0] req_x2 = '0;
    logic [4:0]  req_rd = '0;
    logic [9:0]  fpu_opcode;
    logic [31:0] fpu_x1;
    logic [31:0] fpu_x2;
    logic [31:0] fpu_y = '0;
    logic        fpu_ovf = 1'b0;
    logic        fpu_unf = 1'b0;
    logic        fpu_valid = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ovf;
    logic        wb_unf;
    logic        wb_err;
    logic        busy;
    logic        flags_clr = 1'b0;
    logic [2:0]  flags;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_pulse  = 0;
    logic [2:0]  exp_flags = '0;

    fpu_issue #(.TIMEOUT_CYCLES(8)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x1    (req_x1),
        .req_x2    (req_x2),
        .req_rd    (req_rd),
        .fpu_opcode(fpu_opcode),
        .fpu_x1    (fpu_x1),
        .fpu_x2    (fpu_x2),
        .fpu_y     (fpu_y),
        .fpu_ovf   (fpu_ovf),
        .fpu_unf   (fpu_unf),
        .fpu_valid (fpu_valid),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_ovf    (wb_ovf),
        .wb_unf    (wb_unf),
        .wb_err    (wb_err),
        .busy      (busy),
        .flags_clr (flags_clr),
        .flags     (flags)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (fpu_opcode != '0) n_pulse++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic note_done(input logic [2:0] bits, input logic clr);
`ifdef FPU_ISSUE_STICKY_FLAGS_EN
        exp_flags = clr ? bits : (exp_flags | bits);
`else
        exp_flags = '0;
`endif
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] x1, input logic [31:0] x2,
                          input logic [4:0] rd, input int unsigned lat, input logic [31:0] y,
                          input logic ovf, input logic unf, input int unsigned stall);
        int unsigned p0;
        logic [9:0]  e_op;
        p0 = n_pulse;
        e_op = '0;
        e_op[op] = 1'b1;
        req_valid = 1'b1; req_op = op; req_x1 = x1; req_x2 = x2; req_rd = rd;
        wb_ready = 1'b0;
        tick();
        req_valid = 1'b0; req_x1 = '0; req_x2 = '0;
        check("issue_opcode", 32'(fpu_opcode), 32'(e_op));
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_req_ready", 32'(req_ready), 32'd0);
        check("issue_x1", fpu_x1, x1);
        check("issue_x2", fpu_x2, x2);
        for (int i = 0; i < int'(lat); i++) begin
            tick();
            check("wait_opcode", 32'(fpu_opcode), 32'd0);
            check("wait_wb_valid", 32'(wb_valid), 32'd0);
            check("wait_x1", fpu_x1, x1);
        end
        fpu_valid = 1'b1; fpu_y = y; fpu_ovf = ovf; fpu_unf = unf;
        tick();
        fpu_valid = 1'b0; fpu_y = 32'hDEADBEEF; fpu_ovf = 1'b0; fpu_unf = 1'b0;
        check("wb_valid", 32'(wb_valid), 32'd1);
        check("wb_data", wb_data, y);
        check("wb_rd", 32'(wb_rd), 32'(rd));
        check("wb_status", 32'({wb_err, wb_ovf, wb_unf}), 32'({1'b0, ovf, unf}));
        for (int s = 0; s < int'(stall); s++) begin
            tick();
            check("stall_wb_valid", 32'(wb_valid), 32'd1);
            check("stall_wb_data", wb_data, y);
            check("stall_wb_rd", 32'(wb_rd), 32'(rd));
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        note_done({1'b0, ovf, unf}, 1'b0);
        check("done_req_ready", 32'(req_ready), 32'd1);
        check("done_wb_valid", 32'(wb_valid), 32'd0);
        check("done_pulses", n_pulse - p0, 32'd1);
        check("done_flags", 32'(flags), 32'(exp_flags));
    endtask

    task automatic run_illegal(input logic [3:0] op, input logic [4:0] rd);
        int unsigned p0;
        p0 = n_pulse;
        req_valid = 1'b1; req_op = op; req_x1 = 32'h12345678; req_x2 = 32'h9ABCDEF0; req_rd = rd;
        tick();
        req_valid = 1'b0;
        check("ill_wb_valid", 32'(wb_valid), 32'd1);
        check("ill_wb_err", 32'(wb_err), 32'd1);
        check("ill_wb_data", wb_data, 32'd0);
        check("ill_ovf_unf", 32'({wb_ovf, wb_unf}), 32'd0);
        check("ill_wb_rd", 32'(wb_rd), 32'(rd));
        check("ill_opcode", 32'(fpu_opcode), 32'd0);
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        note_done(3'b100, 1'b0);
        check("ill_req_ready", 32'(req_ready), 32'd1);
        check("ill_pulses", n_pulse - p0, 32'd0);
        check("ill_flags", 32'(flags), 32'(exp_flags));
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_opcode", 32'(fpu_opcode), 32'd0);
        check("rst_fpu_x1", fpu_x1, 32'd0);
        check("rst_fpu_x2", fpu_x2, 32'd0);
        check("rst_wb", 32'({wb_rd, wb_ovf, wb_unf, wb_err}), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        tick();

        run_op(4'd0, 32'h3F800000, 32'h40000000, 5'd5, 3, 32'h40400000, 1'b0, 1'b0, 0);
        run_op(4'd2, 32'h7F000000, 32'h7F000000, 5'd7, 1, 32'h7F800000, 1'b1, 1'b0, 0);
        run_op(4'd9, 32'h3F800000, 32'h40000000, 5'd31, 2, 32'h00000001, 1'b0, 1'b0, 0);
        run_illegal(4'd12, 5'd3);
        run_illegal(4'd10, 5'd4);

        // Timeout: 8 WAIT cycles, flags_clr coincides with the writeback handshake.
        req_valid = 1'b1; req_op = 4'd1; req_x1 = 32'h40A00000; req_x2 = 32'h3F800000; req_rd = 5'd9;
        tick();
        req_valid = 1'b0;
        check("to_issue_opcode", 32'(fpu_opcode), 32'h002);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_wait_wb_valid", 32'(wb_valid), 32'd0);
            check("to_wait_busy", 32'(busy), 32'd1);
        end
        tick();
        check("to_wb_valid", 32'(wb_valid), 32'd1);
        check("to_wb_err", 32'(wb_err), 32'd1);
        check("to_wb_data", wb_data, 32'd0);
        check("to_wb_rd", 32'(wb_rd), 32'd9);
        wb_ready = 1'b1; flags_clr = 1'b1;
        tick();
        wb_ready = 1'b0; flags_clr = 1'b0;
        note_done(3'b100, 1'b1);
        check("to_clr_flags", 32'(flags), 32'(exp_flags));
        fpu_valid = 1'b1; fpu_y = 32'h11111111;
        tick();
        fpu_valid = 1'b0;
        check("late_valid_ready", 32'(req_ready), 32'd1);
        check("late_valid_wb", 32'(wb_valid), 32'd0);
        check("late_valid_busy", 32'(busy), 32'd0);
        check("late_valid_data", wb_data, 32'd0);

        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        note_done(3'b000, 1'b1);
        check("clr_flags", 32'(flags), 32'(exp_flags));

        run_op(4'd4, 32'h40800000, 32'h0, 5'd12, 1, 32'h40000000, 1'b0, 1'b0, 5);

        // Reset in WAIT drops the in-flight fdiv.
        req_valid = 1'b1; req_op = 4'd3; req_x1 = 32'h41200000; req_x2 = 32'h40000000; req_rd = 5'd2;
        tick();
        req_valid = 1'b0;
        tick();
        check("rw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_flags = '0;
        check("rw_req_ready", 32'(req_ready), 32'd1);
        check("rw_wb_valid", 32'(wb_valid), 32'd0);
        check("rw_busy_low", 32'(busy), 32'd0);
        check("rw_flags", 32'(flags), 32'd0);
        check("rw_fpu_x1", fpu_x1, 32'd0);
        tick();
        check("rw_still_idle", 32'(wb_valid), 32'd0);

        run_op(4'd3, 32'h00800000, 32'h40000000, 5'd2, 2, 32'h00400000, 1'b0, 1'b1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
